// File: rtl/controle_quadro_pkg.sv
// Shared types and constants for the received-frame sequencer.
package controle_quadro_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE,
      ESPERA_CAB,
      ESPERA_DADO,
      ESPERA_CHECK,
      FIM_OK,
      FIM_ERRO
   } estado_t;

   // Error codes reported on codigo_erro
   typedef logic [1:0] cod_erro_t;
   localparam cod_erro_t ERR_NONE = 2'b00;
   localparam cod_erro_t ERR_PAR  = 2'b01;
   localparam cod_erro_t ERR_TMO  = 2'b10;
   localparam cod_erro_t ERR_CHK  = 2'b11;

   // Inter-word timeout in clock cycles from clock frequency and microseconds
   function automatic int unsigned ciclos_timeout(input int unsigned clock_hz,
                                                  input int unsigned timeout_us);
      return (clock_hz / 1_000_000) * timeout_us;
   endfunction

endpackage

// File: rtl/controle_quadro_rx_timeout.sv
// Inter-word gap counter: fim_c rises when MAX-1 cycles have been counted.
module contador_timeout #(
   parameter int unsigned MAX = 100
) (
   input  logic clock,
   input  logic reset,
   input  logic limpa,
   input  logic conta,
   output logic fim_c
);

   localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;

   logic [W-1:0] cnt;

   // Clear has priority; saturate at the terminal value
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (limpa) begin
         cnt <= '0;
      end else if (conta && !fim_c) begin
         cnt <= cnt + W'(1);
      end
   end

   assign fim_c = (cnt == W'(MAX - 1));

endmodule

// File: rtl/controle_quadro_rx.sv
// Frame sequencer: header hunt, payload write-out, 16-bit sum check.
module controle_quadro_rx
   import controle_quadro_pkg::*;
#(
   parameter int unsigned N_WORDS    = 4,
   parameter logic [15:0] HEADER     = 16'hA55A,
   parameter int unsigned CLOCK_HZ   = 50_000_000,
   parameter int unsigned TIMEOUT_US = 1000,
   localparam int unsigned AW        = $clog2(N_WORDS)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          habilita,
   input  logic [15:0]   palavra,
   input  logic          pronto_rx,
   input  logic          erro_rx,
   output logic [15:0]   dado_out,
   output logic [AW-1:0] endereco,
   output logic          escreve,
   output logic          quadro_ok,
   output logic          erro_quadro,
   output logic [1:0]    codigo_erro,
   output logic          ocupado
);

   localparam int unsigned TIMEOUT_CYC = ciclos_timeout(CLOCK_HZ, TIMEOUT_US);

   estado_t       estado, estado_n;
   logic [15:0]   soma, soma_n;
   logic [AW-1:0] indice, indice_n;
   cod_erro_t     err_pend, err_pend_n;
   logic [15:0]   dado_n;
   logic [AW-1:0] endereco_n;
   logic          escreve_n, quadro_ok_n, erro_quadro_n, ocupado_n;
   cod_erro_t     codigo_n;
   logic          aceita_cab;
   logic          tmo_limpa, tmo_conta, tmo_fim_c;

   // Gap counter restarts on any received word and on header accept
   assign tmo_limpa = pronto_rx | erro_rx | aceita_cab;
   assign tmo_conta = (estado == ESPERA_DADO) || (estado == ESPERA_CHECK);

   contador_timeout #(.MAX(TIMEOUT_CYC)) u_timeout (
      .clock (clock),
      .reset (reset),
      .limpa (tmo_limpa),
      .conta (tmo_conta),
      .fim_c (tmo_fim_c)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= IDLE;
      end else begin
         estado <= estado_n;
      end
   end

   // Next state and next values of every register; erro_rx > pronto_rx > timeout
   always_comb begin
      estado_n      = estado;
      soma_n        = soma;
      indice_n      = indice;
      err_pend_n    = err_pend;
      dado_n        = dado_out;
      endereco_n    = endereco;
      escreve_n     = 1'b0;
      quadro_ok_n   = 1'b0;
      erro_quadro_n = 1'b0;
      codigo_n      = codigo_erro;
      aceita_cab    = 1'b0;

      if (!habilita) begin
         estado_n = IDLE;
      end else begin
         case (estado)
            IDLE: estado_n = ESPERA_CAB;

            ESPERA_CAB: begin
               if (pronto_rx && (palavra == HEADER)) begin
                  estado_n   = ESPERA_DADO;
                  soma_n     = '0;
                  indice_n   = '0;
                  aceita_cab = 1'b1;
               end
            end

            ESPERA_DADO: begin
               if (erro_rx) begin
                  estado_n   = FIM_ERRO;
                  err_pend_n = ERR_PAR;
               end else if (pronto_rx) begin
                  escreve_n  = 1'b1;
                  dado_n     = palavra;
                  endereco_n = indice;
                  soma_n     = soma + palavra;
                  if (indice == AW'(N_WORDS - 1)) begin
                     estado_n = ESPERA_CHECK;
                  end else begin
                     indice_n = indice + AW'(1);
                  end
               end else if (tmo_fim_c) begin
                  estado_n   = FIM_ERRO;
                  err_pend_n = ERR_TMO;
               end
            end

            ESPERA_CHECK: begin
               if (erro_rx) begin
                  estado_n   = FIM_ERRO;
                  err_pend_n = ERR_PAR;
               end else if (pronto_rx) begin
                  if (palavra == soma) begin
                     estado_n = FIM_OK;
                  end else begin
                     estado_n   = FIM_ERRO;
                     err_pend_n = ERR_CHK;
                  end
               end else if (tmo_fim_c) begin
                  estado_n   = FIM_ERRO;
                  err_pend_n = ERR_TMO;
               end
            end

            FIM_OK: begin
               quadro_ok_n = 1'b1;
               estado_n    = ESPERA_CAB;
            end

            FIM_ERRO: begin
               erro_quadro_n = 1'b1;
               codigo_n      = err_pend;
               estado_n      = ESPERA_CAB;
            end

            default: estado_n = IDLE;
         endcase
      end

      ocupado_n = (estado_n == ESPERA_DADO) || (estado_n == ESPERA_CHECK);
   end

   // Datapath and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         soma        <= '0;
         indice      <= '0;
         err_pend    <= ERR_NONE;
         dado_out    <= '0;
         endereco    <= '0;
         escreve     <= 1'b0;
         quadro_ok   <= 1'b0;
         erro_quadro <= 1'b0;
         codigo_erro <= ERR_NONE;
         ocupado     <= 1'b0;
      end else begin
         soma        <= soma_n;
         indice      <= indice_n;
         err_pend    <= err_pend_n;
         dado_out    <= dado_n;
         endereco    <= endereco_n;
         escreve     <= escreve_n;
         quadro_ok   <= quadro_ok_n;
         erro_quadro <= erro_quadro_n;
         codigo_erro <= codigo_n;
         ocupado     <= ocupado_n;
      end
   end

endmodule
